// File: rtl/cksum_writeback_if.sv
// rtl/cksum_writeback_if.sv - request, header and checksum-unit signals of cksum_writeback
interface cksum_writeback_if #(
  parameter int HDR_MAX_LEN = 64,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
);
  logic                          start_i;
  logic [HDR_MAX_LEN-1:0][7:0]   pkt_hdr_i;
  logic [ADDR_W-1:0]             field_start_i;
  logic [DATA_W-1:0]             field_len_i;
  logic [ADDR_W-1:0]             cksum_pos_i;
  logic                          cs_start_o;
  logic [HDR_MAX_LEN-1:0][7:0]   cs_hdr_o;
  logic [ADDR_W-1:0]             cs_field_start_o;
  logic [DATA_W-1:0]             cs_field_len_o;
  logic [15:0]                   cs_val_i;
  logic                          cs_ready_i;
  logic [HDR_MAX_LEN-1:0][7:0]   pkt_hdr_o;
  logic                          done_o;
  logic                          err_o;

  modport master (
    output start_i, pkt_hdr_i, field_start_i, field_len_i, cksum_pos_i, cs_val_i, cs_ready_i,
    input  cs_start_o, cs_hdr_o, cs_field_start_o, cs_field_len_o, pkt_hdr_o, done_o, err_o
  );

  modport slave (
    input  start_i, pkt_hdr_i, field_start_i, field_len_i, cksum_pos_i, cs_val_i, cs_ready_i,
    output cs_start_o, cs_hdr_o, cs_field_start_o, cs_field_len_o, pkt_hdr_o, done_o, err_o
  );
endinterface

// File: rtl/cksum_writeback.sv
// rtl/cksum_writeback.sv - zeroes a header checksum field, runs the checksum unit, writes the result back big-endian
module cksum_writeback #(
  parameter int HDR_MAX_LEN = 64,
  parameter int TIMEOUT     = 255,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  cksum_writeback_if.slave bus
);
  localparam int IDX_W = $clog2(HDR_MAX_LEN);

  typedef logic [HDR_MAX_LEN-1:0][7:0] hdr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  hdr_t              work;
  hdr_t              wb_hdr;
  logic [ADDR_W-1:0] fs_q;
  logic [DATA_W-1:0] fl_q;
  logic [ADDR_W-1:0] pos_q;
  logic [15:0]       val_q;
  logic [7:0]        cnt;
  logic [IDX_W-1:0]  pos_idx;
  logic [IDX_W-1:0]  pos_idx1;
  logic              geom_bad;

  assign pos_idx  = pos_q[IDX_W-1:0];
  assign pos_idx1 = pos_idx + IDX_W'(1);

  // Bounds are evaluated in 32 bits so start+len cannot wrap past the buffer end.
  always_comb begin
    logic [31:0] fs32;
    logic [31:0] fl32;
    logic [31:0] pos32;
    fs32     = 32'(fs_q);
    fl32     = 32'(fl_q);
    pos32    = 32'(pos_q);
    geom_bad = fl_q[0]
             | (fl_q == '0)
             | ((fs32 + fl32) > 32'(HDR_MAX_LEN))
             | ((pos32 + 32'd2) > 32'(HDR_MAX_LEN))
             | (pos_q[0] ^ fs_q[0]);
  end

  always_comb begin
    wb_hdr           = work;
    wb_hdr[pos_idx]  = val_q[15:8];
    wb_hdr[pos_idx1] = val_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      work                 <= '0;
      fs_q                 <= '0;
      fl_q                 <= '0;
      pos_q                <= '0;
      val_q                <= '0;
      cnt                  <= '0;
      bus.cs_start_o       <= 1'b0;
      bus.cs_hdr_o         <= '0;
      bus.cs_field_start_o <= '0;
      bus.cs_field_len_o   <= '0;
      bus.pkt_hdr_o        <= '0;
      bus.done_o           <= 1'b0;
      bus.err_o            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            work  <= bus.pkt_hdr_i;
            fs_q  <= bus.field_start_i;
            fl_q  <= bus.field_len_i;
            pos_q <= bus.cksum_pos_i;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (geom_bad) begin
            bus.err_o <= 1'b1;
            state     <= S_ERR;
          end else begin
            work[pos_idx]  <= 8'h00;
            work[pos_idx1] <= 8'h00;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          bus.cs_hdr_o         <= work;
          bus.cs_field_start_o <= fs_q;
          bus.cs_field_len_o   <= fl_q;
          bus.cs_start_o       <= 1'b1;
          cnt                  <= '0;
          state                <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still beats the timeout.
          if (bus.cs_ready_i) begin
            val_q <= bus.cs_val_i;
            state <= S_WRITE;
          end else if (cnt == 8'(TIMEOUT)) begin
            bus.cs_start_o <= 1'b0;
            bus.err_o      <= 1'b1;
            state          <= S_ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WRITE: begin
          work           <= wb_hdr;
          bus.pkt_hdr_o  <= wb_hdr;
          bus.done_o     <= 1'b1;
          bus.cs_start_o <= 1'b0;
          state          <= S_DONE;
        end
        S_DONE: begin
          if (!bus.start_i) begin
            bus.done_o <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_ERR: begin
          if (!bus.start_i) begin
            bus.err_o <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
